// File: rtl/pwm_pkg.sv
// Shared constants and types for the PWM Avalon-MM peripheral: register map,
// CTRL/STATUS bit positions and the packed CTRL register layout.
package pwm_pkg;

    localparam logic [1:0] PWM_ADDR_CTRL   = 2'd0;
    localparam logic [1:0] PWM_ADDR_PERIOD = 2'd1;
    localparam logic [1:0] PWM_ADDR_DUTY   = 2'd2;
    localparam logic [1:0] PWM_ADDR_STATUS = 2'd3;

    localparam int PWM_CTRL_ENABLE_BIT   = 0;
    localparam int PWM_CTRL_INVERT_BIT   = 1;
    localparam int PWM_STATUS_WRAP_BIT   = 0;
    localparam int PWM_STATUS_IRQMSK_BIT = 1;

    typedef struct packed {
        logic invert;
        logic enable;
    } pwm_ctrl_t;

endpackage

// File: rtl/pwm_counter_core.sv
// PWM period counter with double-buffered period/duty, compare and registered
// output. The first enabled cycle latches the staged values and starts at 0.
module pwm_counter_core
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             invert,
    input  logic [CNT_W-1:0] period_stage,
    input  logic [CNT_W-1:0] duty_stage,
    output logic             wrap,
    output logic             pwm_out
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             run_q, run_d;
    logic             pwm_q, pwm_d;
    logic             last_cycle;

    always_comb begin
        last_cycle = enable && run_q && (period_q != '0) &&
                     (cnt_q == period_q - CNT_W'(1));
        run_d    = enable;
        cnt_d    = cnt_q;
        period_d = period_q;
        duty_d   = duty_q;
        pwm_d    = invert;
        if (!enable) begin
            cnt_d = '0;
        end else if (!run_q) begin
            cnt_d    = '0;
            period_d = period_stage;
            duty_d   = duty_stage;
        end else begin
            // A zero period never counts and keeps the output inactive.
            pwm_d = ((period_q != '0) && (cnt_q < duty_q)) ^ invert;
            if (last_cycle) begin
                cnt_d    = '0;
                period_d = period_stage;
                duty_d   = duty_stage;
            end else if (period_q != '0) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            duty_q   <= '0;
            run_q    <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            run_q    <= run_d;
            pwm_q    <= pwm_d;
        end
    end

    assign wrap    = last_cycle;
    assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_avalon_slave.sv
// Avalon-MM PWM slave: register decode, staged PERIOD/DUTY, sticky WRAP and
// 1-cycle read path. Define PWM_IRQ_EN to add the irq port and STATUS.IRQ_MASK.
module pwm_avalon_slave
    import pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
`ifdef PWM_IRQ_EN
    output logic        irq,
`endif
    output logic        pwm_out
);

    pwm_ctrl_t        ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             wrap_q, wrap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic [31:0]      rd_mux;
    logic             wrap_pulse;
    logic             wr_status;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_status    = write && (address == PWM_ADDR_STATUS);

`ifdef PWM_IRQ_EN
    logic irq_mask_q, irq_mask_d;
    logic irq_q;
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        if (write && address == PWM_ADDR_CTRL) begin
            ctrl_d.enable = writedata[PWM_CTRL_ENABLE_BIT];
            ctrl_d.invert = writedata[PWM_CTRL_INVERT_BIT];
        end
        if (write && address == PWM_ADDR_PERIOD) period_d = writedata[CNT_W-1:0];
        if (write && address == PWM_ADDR_DUTY)   duty_d   = writedata[CNT_W-1:0];
        // A wrap in the same cycle as a W1C clear keeps the flag set.
        wrap_d = (wrap_q && !(wr_status && writedata[PWM_STATUS_WRAP_BIT])) || wrap_pulse;
`ifdef PWM_IRQ_EN
        irq_mask_d = wr_status ? writedata[PWM_STATUS_IRQMSK_BIT] : irq_mask_q;
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            PWM_ADDR_CTRL: begin
                rd_mux[PWM_CTRL_ENABLE_BIT] = ctrl_q.enable;
                rd_mux[PWM_CTRL_INVERT_BIT] = ctrl_q.invert;
            end
            PWM_ADDR_PERIOD: rd_mux = 32'(period_q);
            PWM_ADDR_DUTY:   rd_mux = 32'(duty_q);
            default: begin
                rd_mux[PWM_STATUS_WRAP_BIT] = wrap_q;
`ifdef PWM_IRQ_EN
                rd_mux[PWM_STATUS_IRQMSK_BIT] = irq_mask_q;
`endif
            end
        endcase
        readdata_d = read ? rd_mux : 32'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            period_q   <= '0;
            duty_q     <= '0;
            wrap_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            period_q   <= period_d;
            duty_q     <= duty_d;
            wrap_q     <= wrap_d;
            readdata_q <= readdata_d;
        end
    end

`ifdef PWM_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= wrap_q && irq_mask_q;
        end
    end

    assign irq = irq_q;
`endif

    assign readdata = readdata_q;

    pwm_counter_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (ctrl_q.enable),
        .invert       (ctrl_q.invert),
        .period_stage (period_q),
        .duty_stage   (duty_q),
        .wrap         (wrap_pulse),
        .pwm_out      (pwm_out)
    );

endmodule

// File: tb/tb_pwm_avalon_slave.sv
// Self-checking bench for pwm_avalon_slave: register table, PWM waveform
// scenarios, double-buffer, boundary, W1C/IRQ and asynchronous reset sequences.
module tb_pwm_avalon_slave;

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_PERIOD = 2'd1;
    localparam logic [1:0] A_DUTY   = 2'd2;
    localparam logic [1:0] A_STATUS = 2'd3;

`ifdef PWM_IRQ_EN
    localparam logic [31:0] MASKBIT = 32'h2;
`else
    localparam logic [31:0] MASKBIT = 32'h0;
`endif

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        pwm_out;
    logic        irq_s;
`ifdef PWM_IRQ_EN
    logic        irq;
    assign irq_s = irq;
`else
    assign irq_s = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    pwm_avalon_slave #(.CNT_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .write     (write),
        .writedata (writedata),
        .read      (read),
        .readdata  (readdata),
`ifdef PWM_IRQ_EN
        .irq       (irq),
`endif
        .pwm_out   (pwm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(posedge clk); #1;
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(posedge clk); #1;
        read = 1'b0;
        d = readdata;
    endtask

    // Runs n cycles after the enabling write; bit rel-1 holds outputs seen after edge rel.
    task automatic run_capture(input int n, input int wr_a, input int wr_b,
                               input logic [1:0] wa, input logic [31:0] wd,
                               input int rd_rel, input logic [1:0] ra,
                               output logic [31:0] pv, output logic [31:0] iv,
                               output logic [31:0] rv);
        pv = '0; iv = '0; rv = '0;
        for (int rel = 1; rel <= n; rel++) begin
            if (rel == wr_a || rel == wr_b) begin
                address = wa; writedata = wd; write = 1'b1;
            end
            if (rel == rd_rel) begin
                address = ra; read = 1'b1;
            end
            @(posedge clk); #1;
            write = 1'b0; read = 1'b0;
            pv[rel-1] = pwm_out;
            iv[rel-1] = irq_s;
            if (rel == rd_rel) rv = readdata;
        end
    endtask

    // Waveform after an enabling write at edge 0: inactive at edge 1, then
    // cnt=(rel-2)%p drives the output; the first period uses d0, later ones d1.
    function automatic logic [31:0] exp_vec(input int p, input int d0, input int d1,
                                            input logic inv, input int n);
        logic [31:0] v;
        int          d;
        v = '0;
        for (int rel = 1; rel <= n; rel++) begin
            if (rel < 2) begin
                v[rel-1] = inv;
            end else begin
                d = (((rel - 2) / p) == 0) ? d0 : d1;
                v[rel-1] = (((rel - 2) % p) < d) ^ inv;
            end
        end
        return v;
    endfunction

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_pwm;
    } reg_vec_t;

    typedef struct {
        int          p;
        int          d;
        logic [31:0] ctrl;
    } scen_t;

    reg_vec_t    tv[8];
    scen_t       sc[4];
    logic [31:0] rd, pv, iv, rv;
    int          highs;

    initial begin
        tv[0] = '{A_PERIOD, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tv[1] = '{A_DUTY,   32'h12345678, 32'h12345678, 1'b0};
        tv[2] = '{A_CTRL,   32'hFFFFFFFE, 32'h00000002, 1'b1};
        tv[3] = '{A_CTRL,   32'h00000000, 32'h00000000, 1'b0};
        tv[4] = '{A_STATUS, 32'hFFFFFFFF, MASKBIT,      1'b0};
        tv[5] = '{A_STATUS, 32'h00000000, 32'h00000000, 1'b0};
        tv[6] = '{A_PERIOD, 32'h0000000A, 32'h0000000A, 1'b0};
        tv[7] = '{A_DUTY,   32'h00000003, 32'h00000003, 1'b0};

        sc[0] = '{10, 3,  32'h1};
        sc[1] = '{10, 0,  32'h1};
        sc[2] = '{10, 10, 32'h1};
        sc[3] = '{10, 3,  32'h3};

        reset_n = 1'b0; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check("reset_readdata", readdata, 32'h0);
        check("reset_pwm", {31'b0, pwm_out}, 32'h0);
        check("reset_irq", {31'b0, irq_s}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus_read(2'(a), rd);
            check($sformatf("reset_reg%0d", a), rd, 32'h0);
        end

        for (int i = 0; i < 8; i++) begin
            bus_write(tv[i].addr, tv[i].wdata);
            bus_read(tv[i].addr, rd);
            check($sformatf("regvec%0d_rd", i), rd, tv[i].exp_rd);
            check($sformatf("regvec%0d_pwm", i), {31'b0, pwm_out}, {31'b0, tv[i].exp_pwm});
        end

        // Simultaneous read and write of PERIOD returns the old value.
        address = A_PERIOD; writedata = 32'h55; write = 1'b1; read = 1'b1;
        @(posedge clk); #1;
        write = 1'b0; read = 1'b0;
        check("rw_same_old", readdata, 32'h0000000A);
        bus_read(A_PERIOD, rd);
        check("rw_same_new", rd, 32'h55);

        for (int s = 0; s < 4; s++) begin
            bus_write(A_CTRL, 32'h0);
            bus_write(A_PERIOD, 32'(sc[s].p));
            bus_write(A_DUTY, 32'(sc[s].d));
            bus_write(A_STATUS, 32'h1);
            bus_write(A_CTRL, sc[s].ctrl);
            run_capture(30, 0, 0, A_CTRL, 32'h0, 0, A_CTRL, pv, iv, rv);
            check($sformatf("scen%0d_p%0d_d%0d_ctrl%0d_wave", s, sc[s].p, sc[s].d, sc[s].ctrl),
                  pv, exp_vec(sc[s].p, sc[s].d, sc[s].d, sc[s].ctrl[1], 30));
            bus_read(A_STATUS, rd);
            check($sformatf("scen%0d_wrap", s), rd, 32'h1);
        end

        // Duty change at cnt=5 only applies from the next period.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_DUTY, 32'd3);
        bus_write(A_CTRL, 32'h1);
        run_capture(30, 7, 0, A_DUTY, 32'd7, 0, A_CTRL, pv, iv, rv);
        check("duty_update_wave", pv, exp_vec(10, 3, 7, 1'b0, 30));

        // PERIOD written on the wrap edge: old staged value loads, new one a period later.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PERIOD, 32'd4);
        bus_write(A_DUTY, 32'd1);
        bus_write(A_CTRL, 32'h1);
        run_capture(30, 5, 0, A_PERIOD, 32'd6, 0, A_CTRL, pv, iv, rv);
        check("period_write_at_wrap_wave", pv, 32'h08208222);

        // Zero period: never active, never wraps.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_PERIOD, 32'd0);
        bus_write(A_DUTY, 32'd5);
        bus_write(A_STATUS, 32'h1);
        bus_write(A_CTRL, 32'h1);
        highs = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            if (pwm_out) highs++;
        end
        check("p0_high_cycles", 32'(highs), 32'd0);
        bus_read(A_STATUS, rd);
        check("p0_wrap", rd, 32'h0);

        // P=4: wraps at edges 5, 9, 13; W1C at 7 clears, W1C at 13 loses to the set.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h3);
        bus_write(A_PERIOD, 32'd4);
        bus_write(A_DUTY, 32'd1);
        bus_write(A_CTRL, 32'h1);
        run_capture(14, 7, 13, A_STATUS, 32'h3, 8, A_STATUS, pv, iv, rv);
        check("w1c_clear_status", rv, MASKBIT);
`ifdef PWM_IRQ_EN
        check("irq_wave", iv, 32'h00003E60);
`endif
        bus_read(A_STATUS, rd);
        check("w1c_set_wins_status", rd, MASKBIT | 32'h1);

        // Asynchronous reset in the middle of a 100 % duty period.
        bus_write(A_CTRL, 32'h0);
        bus_write(A_STATUS, 32'h1);
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_DUTY, 32'd10);
        bus_write(A_CTRL, 32'h1);
        repeat (5) begin
            @(posedge clk); #1;
        end
        check("prereset_pwm", {31'b0, pwm_out}, 32'h1);
        #3 reset_n = 1'b0;
        #1;
        check("async_reset_pwm", {31'b0, pwm_out}, 32'h0);
        check("async_reset_irq", {31'b0, irq_s}, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        highs = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (pwm_out) highs++;
        end
        check("post_reset_idle_high_cycles", 32'(highs), 32'd0);
        bus_read(A_CTRL, rd);
        check("post_reset_ctrl", rd, 32'h0);
        bus_read(A_PERIOD, rd);
        check("post_reset_period", rd, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
